// File: rtl/stream_chk_pkg.sv
// -----------------------------------------------------------------------------
// stream_chk_pkg
// Shared types and helpers for the counting-stream sink checker.
//   state_t  : checker FSM states (IDLE / SYNC / CHECK)
//   sat_inc  : saturating +1 for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package stream_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    // The caller truncates the 32-bit result back to its own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : (v + 32'd1);
    endfunction

endpackage

// File: rtl/stream_seq_checker_stall_gen.sv
// -----------------------------------------------------------------------------
// stall_gen
// Periodic backpressure source. Counts run cycles 0..STALL_PERIOD-1 and
// drops stall_n for the last cycle of each period.
//   sys_clk  : clock
//   sys_rst  : synchronous reset, active-low
//   run      : count this cycle; 0 returns the count to zero
//   stall_n  : 1 = ready may be asserted, 0 = stall cycle
// STALL_PERIOD=0 never stalls; STALL_PERIOD=1 stalls every cycle.
// -----------------------------------------------------------------------------
module stall_gen
#(
    parameter int unsigned STALL_PERIOD = 0
)
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    output logic stall_n
);

    localparam int unsigned LAST = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;
    localparam int unsigned CW   = (LAST > 0) ? $clog2(LAST + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign stall_n = (STALL_PERIOD == 0) || (r_cnt != CW'(LAST));

endmodule

// File: rtl/stream_seq_checker.sv
// -----------------------------------------------------------------------------
// stream_seq_checker
// Sink for a counting-data valid/ready stream. Locks onto the first accepted
// value, then checks every later beat equals previous + 1 (mod 2^DATA_WIDTH).
//   sys_clk   : clock
//   sys_rst   : synchronous reset, active-low
//   en        : 1 = accept and check, 0 = idle
//   clr       : synchronous clear of counters, error capture and lock
//   ivalid    : upstream beat valid
//   idata     : upstream beat data
//   iready    : sink ready (combinational from state, en, stall counter)
//   locked    : first beat received, expected value valid
//   beat_cnt  : accepted beats (saturating)
//   err_cnt   : mismatching beats (saturating)
//   err_flag  : sticky, set on first mismatch
//   first_exp : expected value at first mismatch
//   first_got : received value at first mismatch
// -----------------------------------------------------------------------------
module stream_seq_checker
    import stream_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned STALL_PERIOD = 0
)
(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  iready,
    output logic                  locked,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  err_flag,
    output logic [DATA_WIDTH-1:0] first_exp,
    output logic [DATA_WIDTH-1:0] first_got
);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_locked;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic                  r_err_flag;
    logic [DATA_WIDTH-1:0] r_first_exp;
    logic [DATA_WIDTH-1:0] r_first_got;
    logic [DATA_WIDTH-1:0] r_expected;

    logic                  w_active;
    logic                  w_run;
    logic                  w_stall_n;
    logic                  w_accept;
    logic                  w_mismatch;
    logic [DATA_WIDTH-1:0] w_exp_next;
    logic [CNT_WIDTH-1:0]  w_beat_inc;
    logic [CNT_WIDTH-1:0]  w_err_inc;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_active = (r_state != ST_IDLE);

    // The stall counter only advances in enabled, non-clearing cycles
    // outside IDLE; any other cycle returns it to zero.
    assign w_run = w_active && en && !clr;

    stall_gen #(
        .STALL_PERIOD (STALL_PERIOD)
    ) u_stall_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (w_run),
        .stall_n (w_stall_n)
    );

    assign iready   = en && w_active && w_stall_n;
    assign w_accept = ivalid && iready;

    // ------------------------------------------------------------------
    // Compare and counter arithmetic
    // ------------------------------------------------------------------
    assign w_mismatch = (r_state == ST_CHECK) && (idata != r_expected);
    assign w_exp_next = idata + DATA_WIDTH'(1);
    assign w_beat_inc = CNT_WIDTH'(sat_inc(32'(r_beat_cnt), CNT_WIDTH));
    assign w_err_inc  = CNT_WIDTH'(sat_inc(32'(r_err_cnt), CNT_WIDTH));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = en ? ST_SYNC : ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // A retained lock lets the stream resume without resync.
                    if (en) begin
                        w_next_state = r_locked ? ST_CHECK : ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!en) begin
                        w_next_state = ST_IDLE;
                    end else if (w_accept) begin
                        w_next_state = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!en) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst || clr) begin
            // clr outranks a same-cycle accept: that beat is dropped.
            r_locked    <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_flag  <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
            r_expected  <= '0;
        end else if (w_accept) begin
            // Always resync to the received value so one glitch is one error.
            r_expected <= w_exp_next;
            if (r_state == ST_SYNC) begin
                r_locked   <= 1'b1;
                r_beat_cnt <= CNT_WIDTH'(1);
            end else begin
                r_beat_cnt <= w_beat_inc;
                if (w_mismatch) begin
                    r_err_cnt <= w_err_inc;
                    if (!r_err_flag) begin
                        r_err_flag  <= 1'b1;
                        r_first_exp <= r_expected;
                        r_first_got <= idata;
                    end
                end
            end
        end
    end

    assign locked    = r_locked;
    assign beat_cnt  = r_beat_cnt;
    assign err_cnt   = r_err_cnt;
    assign err_flag  = r_err_flag;
    assign first_exp = r_first_exp;
    assign first_got = r_first_got;

endmodule

// File: tb/tb_stream_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_seq_checker
// Two checkers share one stimulus stream: d0 (CNT_WIDTH=4, no stalls) and
// d1 (CNT_WIDTH=16, STALL_PERIOD=4). A stream-level reference model predicts
// every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_stream_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       ivalid;
    logic [7:0] idata;

    logic       rdy0, lk0, ef0;
    logic [3:0] bc0, ec0;
    logic [7:0] fe0, fg0;

    logic       rdy1, lk1, ef1;
    logic [15:0] bc1, ec1;
    logic [7:0] fe1, fg1;

    int n_checks = 0;
    int n_fail   = 0;

    stream_seq_checker #(
        .DATA_WIDTH   (8),
        .CNT_WIDTH    (4),
        .STALL_PERIOD (0)
    ) u_dut0 (
        .sys_clk   (clk),
        .sys_rst   (rst_n),
        .en        (en),
        .clr       (clr),
        .ivalid    (ivalid),
        .idata     (idata),
        .iready    (rdy0),
        .locked    (lk0),
        .beat_cnt  (bc0),
        .err_cnt   (ec0),
        .err_flag  (ef0),
        .first_exp (fe0),
        .first_got (fg0)
    );

    stream_seq_checker #(
        .DATA_WIDTH   (8),
        .CNT_WIDTH    (16),
        .STALL_PERIOD (4)
    ) u_dut1 (
        .sys_clk   (clk),
        .sys_rst   (rst_n),
        .en        (en),
        .clr       (clr),
        .ivalid    (ivalid),
        .idata     (idata),
        .iready    (rdy1),
        .locked    (lk1),
        .beat_cnt  (bc1),
        .err_cnt   (ec1),
        .err_flag  (ef1),
        .first_exp (fe1),
        .first_got (fg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: per checker, whether it is running, its position
    // in the stall period, and the stream facts seen since the last clear.
    // ------------------------------------------------------------------
    localparam int unsigned PER[2]  = '{0, 4};
    localparam int unsigned CMAX[2] = '{15, 65535};

    bit          m_started = 1'b0;
    bit          m_active[2];
    int unsigned m_phase[2];
    bit          m_locked[2];
    int unsigned m_beats[2];
    int unsigned m_errs[2];
    bit          m_flag[2];
    logic [7:0]  m_exp[2];
    logic [7:0]  m_fexp[2];
    logic [7:0]  m_fgot[2];

    function automatic bit m_rdy(input int k);
        return en && m_active[k] && (PER[k] == 0 || m_phase[k] != PER[k] - 1);
    endfunction

    function automatic void m_clear(input int k);
        m_active[k] = 1'b0;
        m_phase[k]  = 0;
        m_locked[k] = 1'b0;
        m_beats[k]  = 0;
        m_errs[k]   = 0;
        m_flag[k]   = 1'b0;
        m_exp[k]    = 8'd0;
        m_fexp[k]   = 8'd0;
        m_fgot[k]   = 8'd0;
    endfunction

    function automatic void m_step(input int k);
        bit acc;
        acc = ivalid && m_rdy(k);
        if (!rst_n) begin
            m_clear(k);
        end else if (clr) begin
            m_clear(k);
            m_active[k] = en;
        end else if (!en) begin
            m_active[k] = 1'b0;
            m_phase[k]  = 0;
        end else if (!m_active[k]) begin
            m_active[k] = 1'b1;
            m_phase[k]  = 0;
        end else begin
            if (PER[k] > 0) m_phase[k] = (m_phase[k] + 1) % PER[k];
            if (acc) begin
                if (!m_locked[k]) begin
                    m_locked[k] = 1'b1;
                    m_beats[k]  = 1;
                end else begin
                    if (m_beats[k] < CMAX[k]) m_beats[k] = m_beats[k] + 1;
                    if (idata != m_exp[k]) begin
                        if (m_errs[k] < CMAX[k]) m_errs[k] = m_errs[k] + 1;
                        if (!m_flag[k]) begin
                            m_flag[k] = 1'b1;
                            m_fexp[k] = m_exp[k];
                            m_fgot[k] = idata;
                        end
                    end
                end
                m_exp[k] = idata + 8'd1;
            end
        end
    endfunction

    initial begin
        m_clear(0);
        m_clear(1);
        forever begin
            @(posedge clk);
            if (!rst_n) m_started = 1'b1;
            m_step(0);
            m_step(1);
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_dut(input int k, input logic rdy, input logic lk,
                           input logic [31:0] bc, input logic [31:0] ec,
                           input logic ef, input logic [7:0] fe,
                           input logic [7:0] fg);
        chk($sformatf("d%0d_iready", k),    32'(rdy), 32'(m_rdy(k)));
        chk($sformatf("d%0d_locked", k),    32'(lk),  32'(m_locked[k]));
        chk($sformatf("d%0d_beat_cnt", k),  bc,       m_beats[k]);
        chk($sformatf("d%0d_err_cnt", k),   ec,       m_errs[k]);
        chk($sformatf("d%0d_err_flag", k),  32'(ef),  32'(m_flag[k]));
        chk($sformatf("d%0d_first_exp", k), 32'(fe),  32'(m_fexp[k]));
        chk($sformatf("d%0d_first_got", k), 32'(fg),  32'(m_fgot[k]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk_dut(0, rdy0, lk0, 32'(bc0), 32'(ec0), ef0, fe0, fg0);
                chk_dut(1, rdy1, lk1, 32'(bc1), 32'(ec1), ef1, fe1, fg1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit         acc[2];
    bit         rdy_seen[2];
    logic [7:0] tx_q[$];

    // Inputs are set 2 time units after a rising edge and held to the next.
    task automatic cyc();
        #1;
        rdy_seen[0] = rdy0;
        rdy_seen[1] = rdy1;
        acc[0]      = ivalid && rdy0;
        acc[1]      = ivalid && rdy1;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int k);
        int idx;
        idx = 0;
        for (int g = 0; g < 100 && idx < tx_q.size(); g++) begin
            idata  = tx_q[idx];
            ivalid = 1'b1;
            cyc();
            if (acc[k]) idx++;
        end
        chk($sformatf("send_done_d%0d", k), 32'(idx), 32'(tx_q.size()));
        ivalid = 1'b0;
        tx_q.delete();
    endtask

    task automatic do_clr();
        ivalid = 1'b0;
        clr    = 1'b1;
        cyc();
        clr    = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        rst_n  = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        ivalid = 1'b0;
        idata  = 8'd0;
        cyc();
        cyc();

        chk("rst_iready",   32'(rdy0), 32'd0);
        chk("rst_locked",   32'(lk0),  32'd0);
        chk("rst_beat",     32'(bc0),  32'd0);
        chk("rst_err",      32'(ec0),  32'd0);
        chk("rst_flag",     32'(ef0),  32'd0);
        chk("rst_fexp",     32'(fe0),  32'd0);
        chk("rst_fgot",     32'(fg0),  32'd0);
        chk("rst_beat_d1",  32'(bc1),  32'd0);
        rst_n = 1'b1;
        cyc();

        // Lock and count: 5..14
        en     = 1'b1;
        ivalid = 1'b1;
        idata  = 8'd5;
        cyc();
        chk("lock_pre_locked", 32'(lk0), 32'd0);
        chk("lock_pre_beat",   32'(bc0), 32'd0);
        cyc();
        chk("lock_first_locked", 32'(lk0), 32'd1);
        chk("lock_first_beat",   32'(bc0), 32'd1);
        for (int v = 6; v <= 14; v++) tx_q.push_back(8'(v));
        send(0);
        cyc();
        chk("lock_beat",   32'(bc0), 32'd10);
        chk("lock_err",    32'(ec0), 32'd0);
        chk("lock_flag",   32'(ef0), 32'd0);
        chk("lock_locked", 32'(lk0), 32'd1);

        // Wrap-around
        do_clr();
        tx_q = '{8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
        send(0);
        chk("wrap_beat", 32'(bc0), 32'd5);
        chk("wrap_err",  32'(ec0), 32'd0);

        // Single glitch, then a later mismatch
        do_clr();
        tx_q = '{8'd10, 8'd11, 8'd99, 8'd100, 8'd101};
        send(0);
        chk("glitch_err",  32'(ec0), 32'd1);
        chk("glitch_flag", 32'(ef0), 32'd1);
        chk("glitch_fexp", 32'(fe0), 32'd12);
        chk("glitch_fgot", 32'(fg0), 32'd99);
        chk("glitch_beat", 32'(bc0), 32'd5);
        tx_q = '{8'd7};
        send(0);
        chk("glitch2_err",  32'(ec0), 32'd2);
        chk("glitch2_fexp", 32'(fe0), 32'd12);
        chk("glitch2_fgot", 32'(fg0), 32'd99);

        // Backpressure on d1: low on cycles 3,7,11,15,19
        do_clr();
        d = 8'h20;
        for (int i = 0; i < 20; i++) begin
            idata  = d;
            ivalid = 1'b1;
            cyc();
            chk($sformatf("bp_rdy_c%0d", i), 32'(rdy_seen[1]),
                (i % 4 == 3) ? 32'd0 : 32'd1);
            if (acc[1]) d = d + 8'd1;
        end
        ivalid = 1'b0;
        chk("bp_beat",   32'(bc1), 32'd15);
        chk("bp_err",    32'(ec1), 32'd0);
        chk("bp_locked", 32'(lk1), 32'd1);

        // Enable low freezes; re-enable resumes; clr beats a same-cycle accept
        do_clr();
        tx_q = '{8'd1, 8'd2, 8'd3};
        send(0);
        chk("en_pre_beat", 32'(bc0), 32'd3);
        en     = 1'b0;
        ivalid = 1'b1;
        idata  = 8'd4;
        #1;
        chk("en0_iready", 32'(rdy0), 32'd0);
        cyc();
        cyc();
        cyc();
        chk("en0_beat",   32'(bc0), 32'd3);
        chk("en0_locked", 32'(lk0), 32'd1);
        en   = 1'b1;
        tx_q = '{8'd4};
        send(0);
        chk("reen_beat", 32'(bc0), 32'd4);
        chk("reen_err",  32'(ec0), 32'd0);
        clr    = 1'b1;
        ivalid = 1'b1;
        idata  = 8'd5;
        #1;
        chk("clr_iready", 32'(rdy0), 32'd1);
        cyc();
        clr    = 1'b0;
        ivalid = 1'b0;
        chk("clr_beat",   32'(bc0), 32'd0);
        chk("clr_locked", 32'(lk0), 32'd0);

        // Mid-stream reset
        tx_q = '{8'd7, 8'd8, 8'd9};
        send(0);
        chk("mrst_pre_beat", 32'(bc0), 32'd3);
        rst_n  = 1'b0;
        ivalid = 1'b1;
        idata  = 8'd10;
        cyc();
        rst_n  = 1'b1;
        ivalid = 1'b0;
        chk("mrst_iready", 32'(rdy0), 32'd0);
        chk("mrst_locked", 32'(lk0),  32'd0);
        chk("mrst_beat",   32'(bc0),  32'd0);
        chk("mrst_err",    32'(ec0),  32'd0);
        chk("mrst_flag",   32'(ef0),  32'd0);
        chk("mrst_fexp",   32'(fe0),  32'd0);
        chk("mrst_fgot",   32'(fg0),  32'd0);
        chk("mrst_beat_d1", 32'(bc1), 32'd0);
        tx_q = '{8'd50, 8'd51};
        send(0);
        chk("mrst_post_locked", 32'(lk0), 32'd1);
        chk("mrst_post_beat",   32'(bc0), 32'd2);
        chk("mrst_post_err",    32'(ec0), 32'd0);

        // Saturation of 4-bit counters on d0
        do_clr();
        for (int v = 0; v < 20; v++) tx_q.push_back(8'(v));
        send(0);
        chk("sat_beat", 32'(bc0), 32'd15);
        chk("sat_err0", 32'(ec0), 32'd0);
        for (int v = 0; v < 20; v++) tx_q.push_back(8'(100 + 2 * v));
        send(0);
        chk("sat_err",   32'(ec0), 32'd15);
        chk("sat_beat2", 32'(bc0), 32'd15);
        chk("sat_fexp",  32'(fe0), 32'd20);
        chk("sat_fgot",  32'(fg0), 32'd100);

        en = 1'b0;
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
